shadow_key_sched: RTL and testbench
===================================

// Module: shadow_key_sched
// PURPOSE
//  Sequential Shadow round-key generator feeding the round datapath one key per handshake.
//  Parametrised round count; forward (encrypt) or reverse (decrypt) order.
//  Reverse mode fills an internal key buffer first. A repeated decrypt of the same master key skips the refill (cache hit).
// PARAMETERS
//  NR   16  number of round keys emitted, 2..32 (round counter is 5 bits)
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst_n    in   1      synchronous reset, active-low
//  start    in   1      begin a schedule; sampled only in IDLE
//  dec      in   1      0 = forward order rk[0..NR-1], 1 = reverse rk[NR-1..0]; sampled with start
//  key_in   in   [0:63] master key (bit 0 = MSB); sampled with start
//  rk_valid out  1      rk_out/rk_idx valid
//  rk_ready in   1      consumer accepts; transfer = rk_valid & rk_ready
//  rk_out   out  [0:63] round key
//  rk_idx   out  [4:0]  index r of rk_out
//  busy     out  1      high in any state other than IDLE
//  done     out  1      one-cycle pulse the cycle after the final transfer
// BEHAVIOUR
//  Round function F(K,r), K[0:63], r 5-bit:
//   t7=K56&(K56^K62)  t6=K57&(K57^K63)  t5=K58&(K58^K56^K62)  t4=K59&(K59^K57^K63)
//   t3=K60&(K60^K58^K56^K62)  t2=K61&(K61^K59^K57^K63)  t1=K62&(K60^K58^K56)  t0=K63&(K61^K59^K57)
//   c = K[3:7]^r
//   F = {t[7:4],K[16:27],t[3:0],K[28:55],K[0:2],c,K[8:15]}
//  rk[0]=key_in; rk[r+1]=F(rk[r],r).
//  Reset: state=IDLE; rk_valid, busy and done = 0; rk_out=0; rk_idx=0; cache_vld=0. Buffer contents are not reset.
//  States:
//   IDLE: start=1 latches dec and key_in, sets cnt=0.
//     dec=0 -> FWD.
//     dec=1 & cache_vld & key_in==cached_key -> REV.
//     dec=1 otherwise -> FILL, with cache_vld cleared.
//   FWD: rk_out=rk[cnt], rk_idx=cnt, rk_valid=1. On transfer: buf[cnt]<=rk_out, rk_out<=F(rk_out,cnt), cnt++.
//     Transfer with cnt==NR-1 -> IDLE, done pulse; buffer now complete, so cache_vld=1 and cached_key=master.
//   FILL: rk_valid=0; one key per cycle: buf[cnt]<=cur, cur<=F(cur,cnt), cnt++. After writing index NR-1:
//     cache_vld=1, cached_key=master; -> REV.
//   REV: rk_out=buf[idx], rk_idx=idx, starting at idx=NR-1, rk_valid=1. Transfer decrements idx.
//     Transfer at idx==0 -> IDLE, done pulse.
//  Latency from start cycle t:
//   first rk_valid at t+1 for FWD or a cache hit; at t+1+NR for a miss.
//   Back-to-back transfers at 1 key/cycle with rk_ready held high.
//  Handshake:
//   rk_out, rk_idx and rk_valid are registered and held stable while rk_valid & !rk_ready.
//   No combinational path from rk_ready to any output.
//   rk_valid never drops before its transfer.
//  start while busy is ignored; key_in and dec changes while busy are ignored.
//  done and a new start in the same cycle: done pulses, and start is accepted because state is IDLE.
//  rst_n low mid-schedule: next edge returns to IDLE with all outputs 0 and the cache invalidated.
//  cnt/idx arithmetic is 5-bit; NR<=32 guarantees no wrap.
// TESTING
//  1 key_in=0, dec=0, NR=16, rk_ready=1 -> rk[0]=0, rk[1]=0, rk[2]=64'h0000_0000_0000_0100,
//    rk[3]=64'h0000_0000_0001_0200; 16 transfers on consecutive cycles, then done.
//  2 key_in=64'hFFFF_FFFF_FFFF_FFFF, dec=0 -> rk[1]=64'h3FFF_3FFF_FFFF_FFFF; rk_idx counts 0..15.
//  3 Same key, dec=1 after test 2 -> cache hit: first valid at t+1, rk_idx 15..0, keys equal test-2 stream reversed.
//    New key with dec=1 -> first valid at t+17.
//  4 Random rk_ready (50%) in FWD and REV -> rk_out/rk_idx stable during stalls; no key dropped or duplicated vs model.
//  5 Start pulse while busy, and key_in toggled mid-run -> ignored; output stream matches the original key.
//  6 rst_n low at transfer 5 of REV -> IDLE with outputs 0;
//    following dec=1 start with same key is a miss (first valid at t+17).

Source files
------------

// File: rtl/shadow_key_sched_if.sv
// Round-key handshake bundle: schedule request from the host, key stream back to it.
interface shadow_key_sched_if;
  localparam int unsigned KW = 64;
  localparam int unsigned IW = 5;

  logic          start;
  logic          dec;
  logic [KW-1:0] key_in;
  logic          rk_valid;
  logic          rk_ready;
  logic [KW-1:0] rk_out;
  logic [IW-1:0] rk_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, dec, key_in, rk_ready,
    input  rk_valid, rk_out, rk_idx, busy, done
  );

  modport slave (
    input  start, dec, key_in, rk_ready,
    output rk_valid, rk_out, rk_idx, busy, done
  );
endinterface

// File: rtl/shadow_key_sched.sv
// Sequential Shadow round-key generator; forward stream or buffered reverse stream.
// Key bit 0 (MSB in the cipher's numbering) is held in vector bit 63.
module shadow_key_sched #(
  parameter int unsigned NR = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  shadow_key_sched_if.slave bus
);

  localparam int unsigned KW = 64;
  localparam int unsigned IW = 5;
  localparam int unsigned AW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [IW-1:0] LAST = IW'(NR - 1);

  typedef enum logic [1:0] {IDLE, FWD, FILL, REV} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] rk_idx_q, rk_idx_d;
  logic [KW-1:0] rk_out_q, rk_out_d;
  logic [KW-1:0] master_q, master_d;
  logic [KW-1:0] cached_key_q, cached_key_d;
  logic          rk_valid_q, rk_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cache_vld_q, cache_vld_d;

  logic [KW-1:0] key_buf [NR];
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [KW-1:0] buf_wdata;
  logic          xfer;
  logic [KW-1:0] f_key;

  // One Shadow key-schedule step F(K, r)
  function automatic logic [KW-1:0] round_f(input logic [KW-1:0] k, input logic [IW-1:0] r);
    logic [7:0]    t;
    logic [IW-1:0] c;
    t[7] = k[7] & (k[7] ^ k[1]);
    t[6] = k[6] & (k[6] ^ k[0]);
    t[5] = k[5] & (k[5] ^ k[7] ^ k[1]);
    t[4] = k[4] & (k[4] ^ k[6] ^ k[0]);
    t[3] = k[3] & (k[3] ^ k[5] ^ k[7] ^ k[1]);
    t[2] = k[2] & (k[2] ^ k[4] ^ k[6] ^ k[0]);
    t[1] = k[1] & (k[3] ^ k[5] ^ k[7]);
    t[0] = k[0] & (k[2] ^ k[4] ^ k[6]);
    c    = k[60:56] ^ r;
    return {t[7:4], k[47:36], t[3:0], k[35:8], k[63:61], c, k[55:48]};
  endfunction

  assign xfer  = rk_valid_q & bus.rk_ready;
  assign f_key = round_f(rk_out_q, cnt_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rk_idx_d     = rk_idx_q;
    rk_out_d     = rk_out_q;
    rk_valid_d   = rk_valid_q;
    done_d       = 1'b0;
    master_d     = master_q;
    cached_key_d = cached_key_q;
    cache_vld_d  = cache_vld_q;
    buf_we       = 1'b0;
    buf_waddr    = AW'(cnt_q);
    buf_wdata    = rk_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          master_d = bus.key_in;
          cnt_d    = '0;
          rk_idx_d = '0;
          rk_out_d = bus.key_in;
          if (!bus.dec) begin
            state_d    = FWD;
            rk_valid_d = 1'b1;
          end else if (cache_vld_q && (bus.key_in == cached_key_q)) begin
            state_d    = REV;
            cnt_d      = LAST;
            rk_idx_d   = LAST;
            rk_out_d   = key_buf[AW'(LAST)];
            rk_valid_d = 1'b1;
          end else begin
            state_d     = FILL;
            cache_vld_d = 1'b0;
          end
        end
      end
      FWD: begin
        if (xfer) begin
          buf_we   = 1'b1;
          rk_out_d = f_key;
          cnt_d    = cnt_q + IW'(1);
          rk_idx_d = cnt_q + IW'(1);
          if (cnt_q == LAST) begin
            state_d      = IDLE;
            rk_valid_d   = 1'b0;
            done_d       = 1'b1;
            cache_vld_d  = 1'b1;
            cached_key_d = master_q;
          end
        end
      end
      FILL: begin
        buf_we = 1'b1;
        // On the last write rk_out already holds rk[NR-1], the first reverse key
        if (cnt_q == LAST) begin
          state_d      = REV;
          rk_idx_d     = LAST;
          rk_valid_d   = 1'b1;
          cache_vld_d  = 1'b1;
          cached_key_d = master_q;
        end else begin
          rk_out_d = f_key;
          cnt_d    = cnt_q + IW'(1);
        end
      end
      REV: begin
        if (xfer) begin
          if (cnt_q == '0) begin
            state_d    = IDLE;
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            cnt_d    = cnt_q - IW'(1);
            rk_idx_d = cnt_q - IW'(1);
            rk_out_d = key_buf[AW'(cnt_q - IW'(1))];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rk_idx_q     <= '0;
      rk_out_q     <= '0;
      rk_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      master_q     <= '0;
      cached_key_q <= '0;
      cache_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rk_idx_q     <= rk_idx_d;
      rk_out_q     <= rk_out_d;
      rk_valid_q   <= rk_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      master_q     <= master_d;
      cached_key_q <= cached_key_d;
      cache_vld_q  <= cache_vld_d;
    end
  end

  // Key buffer has no reset; validity is tracked by cache_vld_q
  always_ff @(posedge clk) begin
    if (buf_we) key_buf[buf_waddr] <= buf_wdata;
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_out   = rk_out_q;
  assign bus.rk_idx   = rk_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shadow_key_sched.sv
// Bench for shadow_key_sched: vector table, random handshake runs, and corner sequences.
module tb_shadow_key_sched;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shadow_key_sched_if bus();

  shadow_key_sched #(.NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [63:0] m_rk [NR];
  int          exp_idx [$];
  int          exp_lat;
  bit          m_cache_vld = 1'b0;
  logic [63:0] m_cached_key = '0;
  int          commit_kind;
  logic [63:0] pend_key;

  // observations of the last run
  logic [63:0] got_rk [NR];
  int          last_lat;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // field of cipher-numbered bits lo..hi (bit 0 = MSB), as an integer
  function automatic logic [63:0] fld(input logic [63:0] k, input int lo, input int hi);
    return (k >> (63 - hi)) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  function automatic logic [63:0] model_f(input logic [63:0] k, input int r);
    int b [64];
    int t7, t6, t5, t4, t3, t2, t1, t0, hi4, lo4;
    logic [63:0] c;
    for (int p = 0; p < 64; p++) b[p] = int'(fld(k, p, p));
    t7 = b[56] & (b[56] ^ b[62]);
    t6 = b[57] & (b[57] ^ b[63]);
    t5 = b[58] & (b[58] ^ b[56] ^ b[62]);
    t4 = b[59] & (b[59] ^ b[57] ^ b[63]);
    t3 = b[60] & (b[60] ^ b[58] ^ b[56] ^ b[62]);
    t2 = b[61] & (b[61] ^ b[59] ^ b[57] ^ b[63]);
    t1 = b[62] & (b[60] ^ b[58] ^ b[56]);
    t0 = b[63] & (b[61] ^ b[59] ^ b[57]);
    hi4 = t7 * 8 + t6 * 4 + t5 * 2 + t4;
    lo4 = t3 * 8 + t2 * 4 + t1 * 2 + t0;
    c = (fld(k, 3, 7) ^ 64'(r)) & 64'd31;
    return (64'(hi4) << 60) | (fld(k, 16, 27) << 48) | (64'(lo4) << 44) |
           (fld(k, 28, 55) << 16) | (fld(k, 0, 2) << 13) | (c << 8) | fld(k, 8, 15);
  endfunction

  task automatic prep(input logic [63:0] key, input bit d);
    bit hit;
    m_rk[0] = key;
    for (int r = 0; r < NR - 1; r++) m_rk[r + 1] = model_f(m_rk[r], r);
    hit = d && m_cache_vld && (key == m_cached_key);
    exp_lat = (!d || hit) ? 1 : NR + 1;
    exp_idx.delete();
    for (int i = 0; i < NR; i++) exp_idx.push_back(d ? NR - 1 - i : i);
    pend_key = key;
    if (!d) commit_kind = 2;
    else if (hit) commit_kind = 0;
    else begin
      commit_kind = 1;
      m_cache_vld = 1'b0;
    end
    for (int i = 0; i < NR; i++) got_rk[i] = 'x;
    last_lat = 0;
  endtask

  task automatic issue(input logic [63:0] key, input bit d);
    prep(key, d);
    bus.start  = 1'b1;
    bus.dec    = d;
    bus.key_in = key;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic commit();
    m_cache_vld  = 1'b1;
    m_cached_key = pend_key;
    commit_kind  = 0;
  endtask

  // Drives rk_ready and checks the stream; ends just after the edge of the last transfer
  task automatic collect(input bit rnd, input bit disturb, input int stop_after);
    int nx = 0;
    bit stall = 1'b0;
    bit rdy;
    bit fin = 1'b0;
    logic [63:0] po;
    logic [4:0]  pi;
    int idx;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.rk_ready = rdy;
      if (disturb) begin
        bus.start  = ($urandom_range(0, 3) == 0);
        bus.dec    = 1'($urandom_range(0, 1));
        bus.key_in = {$urandom, $urandom};
      end
      @(negedge clk);
      check("busy_in_run", 64'(bus.busy), 64'd1);
      check("done_in_run", 64'(bus.done), 64'd0);
      if (stall) begin
        check("stall_valid", 64'(bus.rk_valid), 64'd1);
        check("stall_out", bus.rk_out, po);
        check("stall_idx", 64'(bus.rk_idx), 64'(pi));
      end
      if (bus.rk_valid && last_lat == 0) begin
        last_lat = cyc + 1;
        check("latency", 64'(last_lat), 64'(exp_lat));
        if (commit_kind == 1) commit();
      end
      if (bus.rk_valid && rdy) begin
        if (exp_idx.size() == 0) begin
          check("extra_xfer", 64'd1, 64'd0);
        end else begin
          idx = exp_idx.pop_front();
          check("rk_idx", 64'(bus.rk_idx), 64'(idx));
          check("rk_out", bus.rk_out, m_rk[idx]);
          got_rk[idx] = bus.rk_out;
        end
        nx++;
      end
      stall = bus.rk_valid && !rdy;
      po = bus.rk_out;
      pi = bus.rk_idx;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (nx == NR) begin
        if (commit_kind == 2) commit();
        fin = 1'b1;
      end
      if (nx == stop_after) fin = 1'b1;
    end
    bus.rk_ready = 1'b1;
    if (!fin) check("run_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_done();
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_valid", 64'(bus.rk_valid), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.rk_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_out"}, bus.rk_out, 64'd0);
    check({tag, "_idx"}, 64'(bus.rk_idx), 64'd0);
  endtask

  typedef struct {
    logic [63:0] key;
    bit          dec;
    int          lat;
    int          idx;
    logic [63:0] val;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [63:0] k;
    logic [63:0] prev_key;
    bit d;

    tbl[0] = '{64'h0, 1'b0, 1, 2, 64'h0000_0000_0000_0100};
    tbl[1] = '{64'h0, 1'b0, 1, 3, 64'h0000_0000_0001_0200};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1, 64'h3FFF_3FFF_FFFF_FFFF};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 1, 64'h3FFF_3FFF_FFFF_FFFF};
    tbl[4] = '{64'h0123_4567_89AB_CDEF, 1'b1, 17, 0, 64'h0123_4567_89AB_CDEF};
    tbl[5] = '{64'h0123_4567_89AB_CDEF, 1'b1, 1, 0, 64'h0123_4567_89AB_CDEF};
    tbl[6] = '{64'h0, 1'b1, 17, 3, 64'h0000_0000_0001_0200};

    bus.start = 1'b0;
    bus.dec = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].key, tbl[i].dec);
      collect(1'b0, 1'b0, -1);
      check($sformatf("vec%0d_lat", i), 64'(last_lat), 64'(tbl[i].lat));
      check($sformatf("vec%0d_rk%0d", i, tbl[i].idx), got_rk[tbl[i].idx], tbl[i].val);
      check_done();
    end

    // random keys, random back-pressure, occasional ignored start/key activity
    prev_key = 64'h0;
    for (int it = 0; it < 16; it++) begin
      k = ($urandom_range(0, 2) == 0) ? prev_key : {$urandom, $urandom};
      d = 1'($urandom_range(0, 1));
      issue(k, d);
      collect(1'b1, (it % 3) == 0, -1);
      check_done();
      prev_key = k;
    end

    // start in the done cycle is accepted
    issue(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    collect(1'b0, 1'b0, -1);
    prep(64'h1357_9BDF_2468_ACE0, 1'b0);
    bus.start  = 1'b1;
    bus.dec    = 1'b0;
    bus.key_in = 64'h1357_9BDF_2468_ACE0;
    @(negedge clk);
    check("done_with_start", 64'(bus.done), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    collect(1'b0, 1'b0, -1);
    check("b2b_lat", 64'(last_lat), 64'd1);
    check_done();

    // reset during reverse streaming invalidates the cache
    issue(64'hA5A5_5A5A_C3C3_3C3C, 1'b1);
    collect(1'b1, 1'b0, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cache_vld = 1'b0;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    issue(64'hA5A5_5A5A_C3C3_3C3C, 1'b1);
    collect(1'b1, 1'b0, -1);
    check("post_rst_miss_lat", 64'(last_lat), 64'(NR + 1));
    check_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
